// File: rtl/capp_multiwrite.sv
// capp_multiwrite
// Parallel multi-write engine for the CAPP cell array. Owns the cell storage
// and a latched command (data, mask, tags). Each accepted command writes the
// masked data word into every tagged cell, one bank of BANK cells per clock,
// then pulses done and publishes the number of tagged cells.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET_N      asynchronous active-low reset
//   cmd_valid    command request
//   cmd_ready    engine idle and able to accept (depends on state only)
//   cmd_data     word to write
//   cmd_mask     bit-enable, 1 = bit written
//   cmd_tags     tag vector, bit i selects cell i
//   busy         sweep or completion cycle in progress
//   done         one-cycle pulse when a sweep completes
//   write_count  tagged-cell count of the last completed command
//   cells        flattened array, cell i at [i*WIDTH +: WIDTH]
module capp_multiwrite #(
  parameter int CELLS = 64,
  parameter int WIDTH = 32,
  parameter int BANK  = 8,
  parameter int CW    = $clog2(CELLS + 1)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_data,
  input  logic [WIDTH-1:0]       cmd_mask,
  input  logic [CELLS-1:0]       cmd_tags,
  output logic                   busy,
  output logic                   done,
  output logic [CW-1:0]          write_count,
  output logic [CELLS*WIDTH-1:0] cells
);

  localparam int NB = CELLS / BANK;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [BW-1:0]          bank_r;
  logic [WIDTH-1:0]       data_r;
  logic [WIDTH-1:0]       mask_r;
  logic [CELLS-1:0]       tags_r;
  logic [CW-1:0]          count_r;
  logic [CW-1:0]          write_count_r;
  logic [CELLS*WIDTH-1:0] cells_r;
  logic [BANK-1:0]        bank_tags_s;
  logic [CELLS-1:0]       wr_en_s;
  logic                   last_bank_s;
  logic                   cmd_ready_s;
  logic                   busy_s;
  logic                   done_s;

  // Number of set bits in one bank's slice of the tag vector.
  function automatic logic [CW-1:0] popcount_bank(input logic [BANK-1:0] t);
    logic [CW-1:0] n;
    n = '0;
    for (int k = 0; k < BANK; k++) begin
      n = n + CW'(t[k]);
    end
    return n;
  endfunction

  assign last_bank_s = (bank_r == BW'(NB - 1));

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next_s = ST_SWEEP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (last_bank_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SWEEP;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Status outputs, decoded from the state register only.
  always_comb begin
    cmd_ready_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE:  cmd_ready_s = 1'b1;
      ST_SWEEP: busy_s      = 1'b1;
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: cmd_ready_s = 1'b0;
    endcase
  end

  // Per-cell write enables and the active bank's tags, selected by bank_r.
  always_comb begin
    bank_tags_s = '0;
    wr_en_s     = '0;
    for (int i = 0; i < CELLS; i++) begin
      bank_tags_s[i % BANK] = bank_tags_s[i % BANK] |
                              (tags_r[i] & (BW'(i / BANK) == bank_r));
      wr_en_s[i] = tags_r[i] & (BW'(i / BANK) == bank_r) & (state_r == ST_SWEEP);
    end
  end

  // Command latch, bank sweep, running count and cell storage.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bank_r        <= '0;
      data_r        <= '0;
      mask_r        <= '0;
      tags_r        <= '0;
      count_r       <= '0;
      write_count_r <= '0;
      cells_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            data_r  <= cmd_data;
            mask_r  <= cmd_mask;
            tags_r  <= cmd_tags;
            count_r <= '0;
            bank_r  <= '0;
          end
        end
        ST_SWEEP: begin
          for (int i = 0; i < CELLS; i++) begin
            if (wr_en_s[i]) begin
              cells_r[i*WIDTH +: WIDTH] <= (cells_r[i*WIDTH +: WIDTH] & ~mask_r) |
                                           (data_r & mask_r);
            end
          end
          count_r <= count_r + popcount_bank(bank_tags_s);
          if (!last_bank_s) begin
            bank_r <= bank_r + BW'(1);
          end
        end
        ST_DONE: write_count_r <= count_r;
        default: bank_r <= '0;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_s;
  assign busy        = busy_s;
  assign done        = done_s;
  assign write_count = write_count_r;
  assign cells       = cells_r;

endmodule

// File: tb/tb_capp_multiwrite.sv
// Directed testbench for capp_multiwrite (default parameters).
module tb_capp_multiwrite;

  localparam int CELLS = 64;
  localparam int WIDTH = 32;
  localparam int CW    = 7;

  logic                   CLK = 1'b0;
  logic                   RESET_N = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic [WIDTH-1:0]       cmd_data = '0;
  logic [WIDTH-1:0]       cmd_mask = '0;
  logic [CELLS-1:0]       cmd_tags = '0;
  logic                   cmd_ready;
  logic                   busy;
  logic                   done;
  logic [CW-1:0]          write_count;
  logic [CELLS*WIDTH-1:0] cells;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_cells [64];

  capp_multiwrite dut (
    .CLK(CLK), .RESET_N(RESET_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_tags(cmd_tags),
    .busy(busy), .done(done), .write_count(write_count), .cells(cells)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] cell_of(input logic [CELLS*WIDTH-1:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  function automatic int popc(input logic [63:0] t);
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(t[i]);
    return n;
  endfunction

  function automatic int first_diff(input logic [CELLS*WIDTH-1:0] a, input logic [CELLS*WIDTH-1:0] b);
    for (int i = 0; i < CELLS; i++)
      if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
    return -1;
  endfunction

  task automatic apply_model(input logic [31:0] d, input logic [31:0] m, input logic [63:0] t);
    for (int i = 0; i < CELLS; i++)
      if (t[i]) ref_cells[i] = (ref_cells[i] & ~m) | (d & m);
  endtask

  task automatic clear_model;
    for (int i = 0; i < CELLS; i++) ref_cells[i] = 32'h0;
  endtask

  // Issue one command and follow it to completion, checking sweep progress.
  task automatic run_cmd(input string name, input logic [31:0] d, input logic [31:0] m, input logic [63:0] t);
    logic [31:0] old_cells [64];
    logic [CELLS*WIDTH-1:0] exp_v;
    int lat;
    int fd;
    old_cells = ref_cells;
    apply_model(d, m, t);
    for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) tick;
    cmd_valid = 1'b1; cmd_data = d; cmd_mask = m; cmd_tags = t;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s_accept_ready: got %b want 1", name, cmd_ready);
    end
    tick;
    cmd_valid = 1'b0; cmd_data = ~d; cmd_mask = ~m; cmd_tags = ~t;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      for (int i = 0; i < CELLS; i++)
        exp_v[i*32 +: 32] = ((i / 8) < (lat - 1)) ? ref_cells[i] : old_cells[i];
      fd = first_diff(cells, exp_v);
      checks++;
      if (fd >= 0) begin
        errors++;
        $display("FAIL %s_sweep_cells cyc %0d cell %0d: got %h want %h", name, lat, fd,
                 cell_of(cells, fd), cell_of(exp_v, fd));
      end
      checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_sweep_status cyc %0d: got ready=%b busy=%b want ready=0 busy=1", name, lat, cmd_ready, busy);
      end
      tick;
      lat++;
    end
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL %s_done_latency: got %0d want 9", name, lat);
    end
    for (int i = 0; i < CELLS; i++) exp_v[i*32 +: 32] = ref_cells[i];
    fd = first_diff(cells, exp_v);
    checks++;
    if (fd >= 0) begin
      errors++;
      $display("FAIL %s_final_cells cell %0d: got %h want %h", name, fd, cell_of(cells, fd), ref_cells[fd]);
    end
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL %s_done_status: got busy=%b ready=%b want busy=1 ready=0", name, busy, cmd_ready);
    end
    tick;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: got done=%b ready=%b busy=%b want 0 1 0", name, done, cmd_ready, busy);
    end
    checks++;
    if (write_count !== CW'(popc(t))) begin
      errors++; $display("FAIL %s_write_count: got %0d want %0d", name, write_count, popc(t));
    end
  endtask

  task automatic test_reset;
    bit seen;
    RESET_N = 1'b0; cmd_valid = 1'b0;
    tick; tick;
    RESET_N = 1'b1;
    clear_model();
    tick;
    checks++;
    if (cells !== '0) begin
      errors++; $display("FAIL reset_cells: got cell0=%h want 0", cell_of(cells, 0));
    end
    checks++;
    if (write_count !== 7'd0) begin
      errors++; $display("FAIL reset_write_count: got %0d want 0", write_count);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_status: got ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done !== 1'b0) seen = 1'b1;
      tick;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_idle_done: got pulse want none");
    end
  endtask

  task automatic test_full_write;
    run_cmd("full", 32'hA5A5A5A5, 32'hFFFFFFFF, {64{1'b1}});
    checks++;
    if (cell_of(cells, 0) !== 32'hA5A5A5A5 || cell_of(cells, 63) !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL full_const_cells: got %h %h want a5a5a5a5", cell_of(cells, 0), cell_of(cells, 63));
    end
    checks++;
    if (write_count !== 7'd64) begin
      errors++; $display("FAIL full_const_count: got %0d want 64", write_count);
    end
  endtask

  task automatic test_masked_sparse;
    run_cmd("preload", 32'h12345678, 32'hFFFFFFFF, {64{1'b1}});
    run_cmd("sparse", 32'hFFFF0000, 32'h00FF0000, 64'h8000_0000_0000_0201);
    checks++;
    if (cell_of(cells, 0) !== 32'h12FF5678 || cell_of(cells, 9) !== 32'h12FF5678 ||
        cell_of(cells, 63) !== 32'h12FF5678) begin
      errors++;
      $display("FAIL sparse_tagged: got %h %h %h want 12ff5678", cell_of(cells, 0), cell_of(cells, 9), cell_of(cells, 63));
    end
    checks++;
    if (cell_of(cells, 1) !== 32'h12345678 || cell_of(cells, 8) !== 32'h12345678 ||
        cell_of(cells, 62) !== 32'h12345678) begin
      errors++;
      $display("FAIL sparse_untagged: got %h %h %h want 12345678", cell_of(cells, 1), cell_of(cells, 8), cell_of(cells, 62));
    end
    checks++;
    if (write_count !== 7'd3) begin
      errors++; $display("FAIL sparse_const_count: got %0d want 3", write_count);
    end
  endtask

  task automatic test_empty;
    run_cmd("empty_tags", 32'hDEADBEEF, 32'hFFFFFFFF, 64'h0);
    checks++;
    if (write_count !== 7'd0 || cell_of(cells, 5) !== 32'h12345678 || cell_of(cells, 0) !== 32'h12FF5678) begin
      errors++;
      $display("FAIL empty_tags_const: got count=%0d c5=%h c0=%h want 0 12345678 12ff5678",
               write_count, cell_of(cells, 5), cell_of(cells, 0));
    end
    run_cmd("zero_mask", 32'hFFFFFFFF, 32'h0, {64{1'b1}});
    checks++;
    if (write_count !== 7'd64 || cell_of(cells, 9) !== 32'h12FF5678 || cell_of(cells, 10) !== 32'h12345678) begin
      errors++;
      $display("FAIL zero_mask_const: got count=%0d c9=%h c10=%h want 64 12ff5678 12345678",
               write_count, cell_of(cells, 9), cell_of(cells, 10));
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] t1 = 64'h0000_0000_FFFF_FFFF;
    logic [63:0] t2 = 64'h0000_0FFF_FFFF_0000;
    logic [CELLS*WIDTH-1:0] exp_v;
    int fd;
    int lat;
    apply_model(32'h0F0F0F0F, 32'hFFFFFFFF, t1);
    apply_model(32'hC3C3C3C3, 32'hFF00FF00, t2);
    for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) tick;
    cmd_valid = 1'b1; cmd_data = 32'h0F0F0F0F; cmd_mask = 32'hFFFFFFFF; cmd_tags = t1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first_accept: got %b want 1", cmd_ready);
    end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick;
      cmd_data = $urandom; cmd_mask = $urandom; cmd_tags = {$urandom, $urandom};
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_ready_low cyc %0d: got %b want 0", cyc, cmd_ready);
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_first_done: got %b want 1", done);
    end
    cmd_data = 32'hC3C3C3C3; cmd_mask = 32'hFF00FF00; cmd_tags = t2;
    tick;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept_at_10: got %b want 1", cmd_ready);
    end
    checks++;
    if (write_count !== 7'd32) begin
      errors++; $display("FAIL b2b_first_count: got %0d want 32", write_count);
    end
    tick;
    cmd_valid = 1'b0; cmd_data = 32'h0; cmd_tags = {64{1'b1}};
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL b2b_second_latency: got %0d want 9", lat);
    end
    tick;
    checks++;
    if (write_count !== 7'd28) begin
      errors++; $display("FAIL b2b_second_count: got %0d want 28", write_count);
    end
    for (int i = 0; i < CELLS; i++) exp_v[i*32 +: 32] = ref_cells[i];
    fd = first_diff(cells, exp_v);
    checks++;
    if (fd >= 0) begin
      errors++;
      $display("FAIL b2b_cells cell %0d: got %h want %h", fd, cell_of(cells, fd), ref_cells[fd]);
    end
    checks++;
    if (cell_of(cells, 20) !== 32'hC30FC30F || cell_of(cells, 40) !== 32'hC334C378) begin
      errors++;
      $display("FAIL b2b_const_cells: got %h %h want c30fc30f c334c378", cell_of(cells, 20), cell_of(cells, 40));
    end
  endtask

  task automatic test_reset_mid_sweep;
    bit seen;
    for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) tick;
    cmd_valid = 1'b1; cmd_data = 32'h55AA55AA; cmd_mask = 32'hFFFFFFFF; cmd_tags = {64{1'b1}};
    tick;
    cmd_valid = 1'b0;
    tick; tick; tick;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (cells !== '0) begin
      errors++; $display("FAIL midrst_cells: got cell0=%h want 0", cell_of(cells, 0));
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || write_count !== 7'd0) begin
      errors++;
      $display("FAIL midrst_status: got busy=%b ready=%b done=%b count=%0d want 0 1 0 0", busy, cmd_ready, done, write_count);
    end
    tick;
    RESET_N = 1'b1;
    clear_model();
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done !== 1'b0) seen = 1'b1;
      tick;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midrst_no_done: got pulse want none");
    end
    run_cmd("after_rst", 32'h3C3C3C3C, 32'hFFFFFFFF, 64'hF0F0_F0F0_F0F0_F0F0);
    checks++;
    if (write_count !== 7'd32 || cell_of(cells, 4) !== 32'h3C3C3C3C || cell_of(cells, 0) !== 32'h0) begin
      errors++;
      $display("FAIL after_rst_const: got count=%0d c4=%h c0=%h want 32 3c3c3c3c 0", write_count, cell_of(cells, 4), cell_of(cells, 0));
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_full_write();
    test_masked_sparse();
    test_empty();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capp_multiwrite.md
# capp_multiwrite

Parallel multi-write engine for the content-addressable parallel processor (CAPP) cell array. It owns the cell storage and a latched tag vector. On each accepted command it writes one masked data word into every tagged cell, sweeping the array one bank per clock. It is the write-side counterpart of the tag-gated read-line OR. Its flattened cell contents feed the read/search logic directly.

## Interface
- CELLS, 64, number of cells in the array; must be a multiple of BANK
- WIDTH, 32, bits per cell
- BANK, 8, cells written per clock; NB = CELLS/BANK sweep cycles
- CW, $clog2(CELLS+1), width of write_count

- CLK  input  1  system clock; all state changes on the rising edge
- RESET_N  input  1  asynchronous, active-low reset; deassertion is synchronous to CLK externally
- cmd_valid  input  1  command request
- cmd_ready  output  1  engine can accept a command
- cmd_data  input  WIDTH  word to write
- cmd_mask  input  WIDTH  bit-enable; 1 = bit is written
- cmd_tags  input  CELLS  tag vector; bit i selects cell i
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when a sweep completes
- write_count  output  CW  number of tagged cells in the last completed command
- cells  output  CELLS*WIDTH  flattened array; cell i occupies bits [i*WIDTH +: WIDTH]

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid && cmd_ready, latch cmd_data, cmd_mask and cmd_tags, clear the running count, set bank=0 and go to SWEEP.
- SWEEP: each cycle, for every cell i in bank b (i = b*BANK .. b*BANK+BANK-1):
  - If tag[i] is set, cell[i] <= (cell[i] & ~mask) | (data & mask).
  - Untagged cells hold their value.
  - Add the popcount of the bank's tags to the count.
  - When b == NB-1, go to DONE; otherwise b <= b+1.
- DONE:
  - done=1 for exactly this cycle.
  - write_count <= final count.
  - Go to IDLE.
- Inputs are sampled only at accept. Changes to cmd_* during SWEEP/DONE are ignored, and cmd_valid is not acknowledged.
- busy=1 in SWEEP and DONE; cmd_ready = (state==IDLE).
- All-zero tags: sweep still runs the full NB cycles; no cell changes; write_count=0.
- All-zero mask: no cell changes; write_count is still the number of tagged cells.
- Count arithmetic is unsigned. The maximum is CELLS, which fits CW bits, so no wrap.
- write_count holds its value between commands and changes only in DONE.
- Reset (any state, including mid-sweep) forces:
  - state=IDLE, all cells=0, write_count=0, done=0, busy=0, cmd_ready=1.
  - A partially written array is not preserved.

## Timing
- Accept on edge T0. Banks 0..NB-1 are written on edges T1..TNB.
- done is high during the cycle after edge TNB (DONE state). The next command can be accepted on edge TNB+2.
- Throughput: one command per NB+2 cycles. Defaults: accept-to-done = 9 edges, period 10 cycles.
- Bank b's new cell values are visible on cells after edge Tb+1. Cells in later banks still show their old values during the sweep.
- No combinational path from cmd_* to any output. cmd_ready depends on state only.

## Test plan
- Reset then idle: after RESET_N rises, cells=0, write_count=0, cmd_ready=1, busy=0, done never pulses with cmd_valid=0.
- Full write: tags=all ones, data=0xA5A5A5A5, mask=0xFFFFFFFF -> done exactly 9 cycles after accept, every cell=0xA5A5A5A5, write_count=64.
- Masked sparse write:
  - Preload all cells with 0x12345678.
  - Send tags with bits 0, 9, 63 set, data=0xFFFF0000, mask=0x00FF0000.
  - Expect cells 0/9/63 = 0x12FF5678, all other cells unchanged, write_count=3.
- Empty tags and zero mask:
  - tags=0 -> write_count=0, no cell change, done still at cycle 9.
  - tags=all ones, mask=0 -> no cell change, write_count=64.
- Back-to-back and input stability:
  - Hold cmd_valid=1 with changing data across two commands. Expect the second accept exactly 10 cycles after the first, and cmd_ready low throughout SWEEP/DONE.
  - Mid-sweep changes to cmd_tags/cmd_data have no effect.
- Reset mid-sweep: assert RESET_N low at sweep cycle 4 -> cells=0, busy=0, no done pulse. A new command after release completes normally.
